// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl
//  Purpose  : Hazard and memory-stall controller for a five-stage pipeline.
//             Generates register load enables, bubble (flush) controls and the
//             branch-target select. Also holds the data-memory handshake and
//             counts the cycles in which the PC is frozen.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    MEM_TMO      MEMWAIT cycles allowed before a timeout is declared
//                 (only used when MEM_TIMEOUT_EN is defined)
//  Optional feature macro
//    MEM_TIMEOUT_EN  when defined, a stalled memory access is abandoned after
//                    MEM_TMO wait cycles and the sticky mem_err flag is set.
//                    When undefined, the wait never times out and mem_err is 0.
//  Ports
//    clk, rst                 clock (rising edge), synchronous active-high reset
//    id_rs, id_rt       [4:0] source register indices of the ID instruction
//    ex_regdst          [4:0] destination index of the EX instruction
//    ex_memread               EX holds a load
//    mm_branch, mm_zero       MM holds a branch / compare result
//    mm_memread, mm_memwrite  MM holds a load / store
//    dmem_ack                 data memory completes the access this cycle
//    dmem_req                 data memory request, held until acknowledged
//    pc_en, ifid_en, exmm_en  register load enables
//    ifid_flush, idex_flush, exmm_flush, mmwb_flush   bubble insertion
//    pc_src                   select branch target
//    busy                     controller is waiting on data memory
//    mem_err                  sticky memory timeout flag
//    stall_cnt         [15:0] saturating count of cycles with pc_en = 0
// ============================================================================
module pipe_ctrl #(
    parameter int MEM_TMO = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  ex_regdst,
    input  logic        ex_memread,
    input  logic        mm_branch,
    input  logic        mm_zero,
    input  logic        mm_memread,
    input  logic        mm_memwrite,
    input  logic        dmem_ack,
    output logic        dmem_req,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        exmm_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmm_flush,
    output logic        mmwb_flush,
    output logic        pc_src,
    output logic        busy,
    output logic        mem_err,
    output logic [15:0] stall_cnt
);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MEMWAIT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic w_mem_op;
    logic w_branch_taken;
    logic w_load_use;
    logic w_timeout;

    assign w_mem_op       = mm_memread | mm_memwrite;
    assign w_branch_taken = mm_branch & mm_zero;
    // Register 0 is hard-wired, so a load targeting it can never create a hazard.
    assign w_load_use     = ex_memread && (ex_regdst != 5'd0) &&
                            ((ex_regdst == id_rs) || (ex_regdst == id_rt));

    // A zero-cycle timeout has no meaning; the compare below assumes MEM_TMO >= 1.
    if (MEM_TMO < 1) begin : g_tmo_range_hook
    end

`ifdef MEM_TIMEOUT_EN
    localparam int c_tmo_w = ($clog2(MEM_TMO + 1) > 4) ? $clog2(MEM_TMO + 1) : 4;
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(MEM_TMO - 1);

    logic [c_tmo_w-1:0] r_tmo_cnt;

    // The counter holds the number of unacknowledged wait cycles already spent,
    // so the MEM_TMO-th such cycle is the one that gives up.
    assign w_timeout = (r_state == ST_MEMWAIT) && !dmem_ack && (r_tmo_cnt == c_tmo_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
            mem_err   <= 1'b0;
        end else begin
            if ((r_state == ST_RUN) && (w_next_state == ST_MEMWAIT)) begin
                r_tmo_cnt <= '0;
            end else if ((r_state == ST_MEMWAIT) && !dmem_ack) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
            if (w_timeout) begin
                mem_err <= 1'b1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign mem_err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        dmem_req     = 1'b0;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        exmm_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmm_flush   = 1'b0;
        mmwb_flush   = 1'b0;
        pc_src       = 1'b0;

        if (rst) begin
            w_next_state = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    dmem_req = w_mem_op;
                    if (w_mem_op && !dmem_ack) begin
                        // Freeze everything up to MM; MM/WB gets a bubble so the
                        // stalled access is not retired twice.
                        pc_en        = 1'b0;
                        ifid_en      = 1'b0;
                        exmm_en      = 1'b0;
                        mmwb_flush   = 1'b1;
                        w_next_state = ST_MEMWAIT;
                    end else if (w_branch_taken) begin
                        pc_src     = 1'b1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        exmm_flush = 1'b1;
                    end else if (w_load_use) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
                ST_MEMWAIT: begin
                    dmem_req = 1'b1;
                    if (dmem_ack || w_timeout) begin
                        w_next_state = ST_RUN;
                    end else begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        exmm_en    = 1'b0;
                        mmwb_flush = 1'b1;
                    end
                end
                default: begin
                    w_next_state = ST_RUN;
                end
            endcase
        end
    end

    assign busy = (r_state == ST_MEMWAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 16'd0;
        end else if (!pc_en && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule
`default_nettype wire
